// File: rtl/jk_bank_ctrl.sv
// Command-driven controller for a bank of WIDTH JK flip-flops.
// It supports hold, clear, preset, toggle and load commands, plus up/down counting for DATA steps.
module jk_cell (
  input  logic CLK,
  input  logic RST,
  input  logic J,
  input  logic K,
  output logic Q
);
  always_ff @(posedge CLK) begin
    if (RST) Q <= 1'b0;
    else     Q <= (J & ~Q) | (~K & Q);
  end
endmodule

module jk_bank_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ,
  input  logic [2:0]       CMD,
  input  logic [WIDTH-1:0] DATA,
  output logic             BUSY,
  output logic             ACK,
  output logic             ERR,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K,
  output logic [WIDTH-1:0] Q
);
  typedef enum logic [1:0] {IDLE, APPLY, COUNT, DONE} state_t;

  localparam logic [2:0] C_CLEAR = 3'b001, C_PRESET = 3'b010, C_TOGGLE = 3'b011,
                         C_LOAD  = 3'b100, C_UP     = 3'b101, C_DOWN   = 3'b110,
                         C_RSVD  = 3'b111;

  state_t           state, state_nxt;
  logic [2:0]       cmd_r;
  logic [WIDTH-1:0] data_r, cnt;
  logic [WIDTH-1:0] up_t, dn_t;
  logic             accept;

  assign accept = (state == IDLE) && REQ;

  // Ripple toggle enables: up toggles bit i when all lower bits are 1, down when all are 0.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    if (i == 0) begin : g_lsb
      assign up_t[i] = 1'b1;
      assign dn_t[i] = 1'b1;
    end else begin : g_upper
      assign up_t[i] = &Q[i-1:0];
      assign dn_t[i] = ~|Q[i-1:0];
    end
    jk_cell u_cell (.CLK(CLK), .RST(RST), .J(J[i]), .K(K[i]), .Q(Q[i]));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      cmd_r  <= '0;
      data_r <= '0;
      cnt    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cmd_r  <= CMD;
        data_r <= DATA;
        cnt    <= DATA;
      end else if (state == COUNT) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (REQ) begin
               if (CMD == C_UP || CMD == C_DOWN) state_nxt = (DATA != '0) ? COUNT : DONE;
               else                              state_nxt = APPLY;
             end
      APPLY: state_nxt = DONE;
      COUNT: if (cnt == WIDTH'(1)) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    J = '0;
    K = '0;
    if (state == APPLY) begin
      case (cmd_r)
        C_CLEAR:  K = '1;
        C_PRESET: J = '1;
        C_TOGGLE: begin J = '1; K = '1; end
        C_LOAD:   begin J = data_r; K = ~data_r; end
        default:  ;
      endcase
    end else if (state == COUNT) begin
      J = (cmd_r == C_UP) ? up_t : dn_t;
      K = J;
    end
  end

  assign BUSY = (state != IDLE);
  assign ACK  = (state == DONE);
  assign ERR  = ACK && (cmd_r == C_RSVD);
endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Directed bench for jk_bank_ctrl: expected completions are queued at issue and matched on ACK.
module tb_jk_bank_ctrl;
  logic       CLK = 1'b0;
  logic       RST, REQ, BUSY, ACK, ERR;
  logic [2:0] CMD;
  logic [3:0] DATA, J, K, Q;

  jk_bank_ctrl #(.WIDTH(4)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .CMD(CMD), .DATA(DATA),
    .BUSY(BUSY), .ACK(ACK), .ERR(ERR), .J(J), .K(K), .Q(Q)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       err;
    logic [3:0] q;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Monitor: every ACK must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (ACK === 1'b1) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_ack: got ACK with Q=%0h expected no ACK", Q);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ack_q", 32'(Q), 32'(e.q));
        chk("ack_err", 32'(ERR), 32'(e.err));
      end
    end
  end

  // Called away from the rising edge; returns just after the accepting edge with inputs scrambled.
  task automatic start(input logic [2:0] cmd, input logic [3:0] data,
                       input logic push, input logic err, input logic [3:0] q);
    REQ = 1'b1; CMD = cmd; DATA = data;
    if (push) sb.push_back('{err: err, q: q});
    @(posedge CLK);
    #1;
    REQ = 1'b0; CMD = ~cmd; DATA = ~data;
  endtask

  // Checks BUSY, ACK and Q for each busy cycle, then that the block is idle again.
  task automatic busy_seq(input string name, input int n, input logic [31:0] seq);
    for (int k = 0; k < n; k++) begin
      @(negedge CLK);
      chk({name, "_busy"}, 32'(BUSY), 32'd1);
      chk({name, "_ack"}, 32'(ACK), 32'(k == n - 1));
      chk({name, "_q"}, 32'(Q), 32'(seq[4*k +: 4]));
    end
    @(negedge CLK);
    chk({name, "_idle"}, 32'(BUSY), 32'd0);
  endtask

  initial begin
    RST = 1'b1; REQ = 1'b0; CMD = 3'b000; DATA = 4'h0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_q", 32'(Q), 32'h0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_ack_err", {ACK, ERR}, 32'd0);
    chk("rst_jk", {J, K}, 32'h0);
    RST = 1'b0;

    // PRESET from reset: J drives all ones during APPLY, Q=1111 one edge later.
    start(3'b010, 4'h0, 1'b1, 1'b0, 4'hF);
    @(negedge CLK);
    chk("preset_jk", {J, K}, {4'hF, 4'h0});
    chk("preset_q0", 32'(Q), 32'h0);
    busy_seq("preset", 1, 32'hF);

    // LOAD 1010 from 1111, then TOGGLE.
    start(3'b100, 4'hA, 1'b1, 1'b0, 4'hA);
    @(negedge CLK);
    chk("load_jk", {J, K}, {4'hA, 4'h5});
    busy_seq("load", 1, 32'hA);
    start(3'b011, 4'h0, 1'b1, 1'b0, 4'h5);
    busy_seq("toggle", 2, 32'h5A);

    // COUNT_UP 3 from 1110, wrapping through 0000.
    start(3'b100, 4'hE, 1'b1, 1'b0, 4'hE);
    busy_seq("load_e", 2, 32'hE5);
    start(3'b101, 4'h3, 1'b1, 1'b0, 4'h1);
    busy_seq("up3", 4, 32'h10FE);

    // COUNT_DOWN 2 from 0001, then COUNT_UP 0 completes at once.
    start(3'b110, 4'h2, 1'b1, 1'b0, 4'hF);
    busy_seq("dn2", 3, 32'hF01);
    start(3'b101, 4'h0, 1'b1, 1'b0, 4'hF);
    busy_seq("up0", 1, 32'hF);

    // Reserved command: ERR with ACK, and a CLEAR request during BUSY is dropped.
    start(3'b111, 4'h0, 1'b1, 1'b1, 4'hF);
    @(negedge CLK);
    chk("rsvd_jk", {J, K}, 32'h0);
    REQ = 1'b1; CMD = 3'b001;
    @(negedge CLK);
    chk("rsvd_busy", 32'(BUSY), 32'd1);
    REQ = 1'b0;
    @(negedge CLK);
    chk("rsvd_idle", 32'(BUSY), 32'd0);
    repeat (3) @(negedge CLK);
    chk("rsvd_q_hold", 32'(Q), 32'hF);

    // Long count aborted by reset, then a CLEAR right after reset releases.
    start(3'b001, 4'h0, 1'b1, 1'b0, 4'h0);
    busy_seq("clear1", 2, 32'h0F);
    start(3'b101, 4'hF, 1'b0, 1'b0, 4'h0);
    repeat (5) @(posedge CLK);
    @(negedge CLK);
    chk("abort_q5", 32'(Q), 32'h5);
    RST = 1'b1;
    @(negedge CLK);
    chk("abort_q", 32'(Q), 32'h0);
    chk("abort_busy", 32'(BUSY), 32'd0);
    chk("abort_jk", {J, K}, 32'h0);
    RST = 1'b0;
    start(3'b001, 4'h0, 1'b1, 1'b0, 4'h0);
    busy_seq("clear2", 2, 32'h00);
    repeat (4) @(negedge CLK);
    chk("after_q", 32'(Q), 32'h0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no completion expected finish");
    $fatal(1);
  end
endmodule
